vga_scanout: RTL
================

Name: vga_scanout

Overview:
- Display scan-out stage downstream of the GPU framebuffer RAM, in the gpu_clk domain.
- Generates VGA timing and drives the RAM's GPU read port (gpu_address).
- Consumes the word returned on gpu_bus and drives registered RGB444 pixels plus HS/VS to the VGA connector.
- Upscales a small framebuffer (default 160x120) to 640x480 by pixel replication.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 2, log2 replication factor; FB_W = H_ACTIVE>>SCALE_SHIFT, FB_H = V_ACTIVE>>SCALE_SHIFT
- BASE_WORD, 0, word address of framebuffer pixel (0,0) on the GPU port
- WORD_LENGTH, 12, framebuffer word width, must be >= 12

Ports:
- gpu_clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = show framebuffer, 0 = black output (sync timing keeps running)
- gpu_address  out  30  word address to the RAM GPU port, registered
- gpu_bus  in  WORD_LENGTH  RAM read data, valid one gpu_clk after gpu_address changes
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async, immediate): h_cnt=0, v_cnt=0, all pipeline registers cleared. Outputs: gpu_address=BASE_WORD, rgb=0, vga_hs=1, vga_vs=1, frame_start=0.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), then wraps to 0.
  - v_cnt increments on each h wrap and runs 0..V_TOTAL-1 (525), then wraps.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Sync windows:
  - hs_raw low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Pipeline (3 stages, fixed latency 2 cycles counter -> pins):
  - S0: counters, active, hs_raw/vs_raw.
  - S1: gpu_address registered. When active: BASE_WORD + row_base + (h_cnt>>SCALE_SHIFT). When blanking: BASE_WORD. active/hs/vs/first-pixel flag delayed one stage.
  - RAM samples the address on the negedge inside S1; gpu_bus is stable at the S2 edge.
  - S2: rgb registered. R=gpu_bus[11:8], G=gpu_bus[7:4], B=gpu_bus[3:0]. rgb is forced 0 if delayed active=0 or enable=0 (enable sampled at the S2 edge). vga_hs/vga_vs registered from the two-stage-delayed sync flags.
- Address arithmetic: no multiplier.
  - row_base is a register, 0 at v_cnt=0.
  - row_base += FB_W when the h wrap moves v_cnt across a multiple of 2^SCALE_SHIFT inside the active region.
  - row_base is cleared at the v wrap.
  - Maximum address = BASE_WORD + FB_W*FB_H - 1. All arithmetic is 30-bit unsigned with no overflow for legal parameters.
- frame_start: 1 for exactly the cycle in which output pixel (0,0) is on vga_r/g/b, i.e. two cycles after h_cnt=0, v_cnt=0.
- Simultaneous h and v wrap: v_cnt and row_base both return to 0 on the same edge.
- Upper gpu_bus bits above bit 11 are ignored.
- enable toggling mid-line affects only rgb, from the next S2 edge. Counters and sync are never stalled.
- Reset asserted mid-frame: outputs take reset values with no clock edge. After release, the frame restarts at h=0, v=0. The first valid pixel appears 2 cycles after the first rising edge following release.

Decomposition:
- Shared package gpu_pkg holds:
  - 640x480@60 timing constants (defaults of the H_*/V_* params)
  - RGB444 field positions (R_MSB=11, G_MSB=7, B_MSB=3)
  - H_TOTAL/V_TOTAL helper constants
- Sub-module vga_timing: counters, active, hs_raw/vs_raw, and the wrap strobes used by the row_base logic.
- vga_scanout holds the address generator and the S1/S2 alignment pipeline.

Test Plan:
- Reset release, enable=1 -> vga_hs period 800 clocks, low for 96 clocks starting 658 clocks after reset release. vga_vs period 420000 clocks, low for 1600 clocks.
- Address trace on line 0 -> gpu_address 0,0,0,0,1,1,1,1,...,159 over h 0..639. Lines 0-3 identical. Line 4 starts at 160. Pixel (639,479) uses 19199. Blanking cycles show 0.
- RAM model with 1-cycle latency returning word=address&0xFFF -> output pixel at column h of line 0 shows rgb = h>>2. frame_start pulses exactly with pixel (0,0) of rgb.
- RAM model forced to 0xFFF -> rgb=0 during every blanking cycle, 0xFFF during every active cycle.
- enable dropped at h=300 of line 10 -> rgb=0 from the following output cycle. hs/vs periods unchanged. Re-raising enable restores pixels the next cycle.
- rst_n pulsed low at h=400, v=200 between clock edges -> vga_hs=vga_vs=1, rgb=0, gpu_address=BASE_WORD immediately. After release the sequence restarts from pixel (0,0) with frame_start 2 cycles after the first edge.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU display constants: 640x480@60 timing defaults,
// RGB444 field positions and the scan-out pipeline bundle.
package gpu_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL = H_ACTIVE_D + H_FP_D
                         + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL = V_ACTIVE_D + V_FP_D
                         + V_SYNC_D + V_BP_D;

  localparam int R_MSB = 11;
  localparam int G_MSB = 7;
  localparam int B_MSB = 3;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } s1_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer RAM read port seen from the scan-out stage.
// The scan-out drives the address; the RAM returns the word.
interface vga_scanout_if #(
  parameter int WORD_LENGTH = 12
);
  logic [29:0]            gpu_address;
  logic [WORD_LENGTH-1:0] gpu_bus;

  modport master (
    output gpu_address,
    input  gpu_bus
  );

  modport slave (
    input  gpu_address,
    output gpu_bus
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster counters, active window, raw sync levels and
// the wrap strobes consumed by the row address logic.
module vga_timing
  import gpu_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic clk,
  input  logic rst_n,
  output cnt_t h_cnt_o,
  output cnt_t v_cnt_o,
  output logic active_o,
  output logic hs_raw_o,
  output logic vs_raw_o,
  output logic h_wrap_o,
  output logic v_wrap_o
);

  localparam cnt_t HA  = cnt_t'(H_ACTIVE);
  localparam cnt_t HS0 = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS1 = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t HT1 = cnt_t'(H_ACTIVE + H_FP
                              + H_SYNC + H_BP - 1);
  localparam cnt_t VA  = cnt_t'(V_ACTIVE);
  localparam cnt_t VS0 = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS1 = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t VT1 = cnt_t'(V_ACTIVE + V_FP
                              + V_SYNC + V_BP - 1);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  always_comb begin
    h_wrap_o = (h_q == HT1);
    v_wrap_o = h_wrap_o && (v_q == VT1);
    h_d = h_wrap_o ? '0 : h_q + cnt_t'(1);
    v_d = v_q;
    if (h_wrap_o) begin
      v_d = v_wrap_o ? '0 : v_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o  = h_q;
  assign v_cnt_o  = v_q;
  assign active_o = (h_q < HA) && (v_q < VA);
  assign hs_raw_o = !((h_q >= HS0) && (h_q < HS1));
  assign vs_raw_o = !((v_q >= VS0) && (v_q < VS1));

endmodule

// File: rtl/vga_scanout.sv
// Scan-out stage: framebuffer address generation with pixel
// replication, then RAM word to registered RGB444 and syncs.
module vga_scanout
  import gpu_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_D,
  parameter int H_FP        = H_FP_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int H_BP        = H_BP_D,
  parameter int V_ACTIVE    = V_ACTIVE_D,
  parameter int V_FP        = V_FP_D,
  parameter int V_SYNC      = V_SYNC_D,
  parameter int V_BP        = V_BP_D,
  parameter int SCALE_SHIFT = 2,
  parameter int BASE_WORD   = 0,
  parameter int WORD_LENGTH = 12
) (
  input  logic                gpu_clk,
  input  logic                rst_n,
  input  logic                enable,
  vga_scanout_if.master       bus,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                frame_start
);

  localparam logic [29:0] BASE = 30'(BASE_WORD);
  localparam logic [29:0] FB_W = 30'(H_ACTIVE >> SCALE_SHIFT);
  localparam cnt_t        VA   = cnt_t'(V_ACTIVE);

  cnt_t h_cnt, v_cnt, v_nxt;
  logic active, hs_raw, vs_raw, h_wrap, v_wrap;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (gpu_clk),
    .rst_n    (rst_n),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .active_o (active),
    .hs_raw_o (hs_raw),
    .vs_raw_o (vs_raw),
    .h_wrap_o (h_wrap),
    .v_wrap_o (v_wrap)
  );

  logic [29:0] row_q, row_d;
  logic [29:0] addr_q, addr_d;
  logic        row_step;
  s1_t         s1_q, s1_d;
  logic [3:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q, fs_q;

  logic [WORD_LENGTH-1:0] word;
  logic                   unused_word;
  assign word        = bus.gpu_bus;
  assign unused_word = ^word;

  // A new framebuffer row begins every 2^SCALE_SHIFT lines.
  always_comb begin
    v_nxt    = v_cnt + cnt_t'(1);
    row_step = h_wrap && !v_wrap && (v_nxt < VA)
            && (((v_nxt >> SCALE_SHIFT) << SCALE_SHIFT) == v_nxt);
    row_d    = row_q;
    if (v_wrap) begin
      row_d = '0;
    end else if (row_step) begin
      row_d = row_q + FB_W;
    end
    addr_d = active
           ? BASE + row_q + 30'(h_cnt >> SCALE_SHIFT)
           : BASE;
    s1_d.act   = active;
    s1_d.hs    = hs_raw;
    s1_d.vs    = vs_raw;
    s1_d.first = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge gpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      addr_q <= BASE;
      s1_q   <= '{act: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      row_q  <= row_d;
      addr_q <= addr_d;
      s1_q   <= s1_d;
      if (s1_q.act && enable) begin
        r_q <= word[R_MSB -: 4];
        g_q <= word[G_MSB -: 4];
        b_q <= word[B_MSB -: 4];
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
      hs_q <= s1_q.hs;
      vs_q <= s1_q.vs;
      fs_q <= s1_q.first;
    end
  end

  assign bus.gpu_address = addr_q;
  assign vga_r           = r_q;
  assign vga_g           = g_q;
  assign vga_b           = b_q;
  assign vga_hs          = hs_q;
  assign vga_vs          = vs_q;
  assign frame_start     = fs_q;

endmodule
